// File: rtl/led_mux_arbiter_if.sv
// led_mux_arbiter_if: request/data/grant bundle between two LED sources and the arbiter
interface led_mux_arbiter_if #(parameter int WIDTH = 8);
  logic [1:0]       req;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [1:0]       gnt;
  logic             sel;
  logic [WIDTH-1:0] m;
  logic             busy;
  modport master (output req, data_a, data_b, input gnt, sel, m, busy);
  modport slave  (input req, data_a, data_b, output gnt, sel, m, busy);
endinterface

// File: rtl/led_mux_arbiter.sv
// led_mux_arbiter: two-source round-robin arbiter with hold timeout driving a shared LED bus
module led_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input logic               CLOCK_50,
  input logic               reset,
  led_mux_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  // Release and timeout share one exit path; the owner only stays if nobody else waits.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.req == 2'b01 ? GRANT_A :
                         bus.req == 2'b10 ? GRANT_B :
                         bus.req == 2'b11 ? (last_q ? GRANT_A : GRANT_B) : IDLE;
      GRANT_A: state_d = (!bus.req[0] || cnt_q == LAST) ?
                         (bus.req[1] ? GRANT_B : bus.req[0] ? GRANT_A : IDLE) : GRANT_A;
      GRANT_B: state_d = (!bus.req[1] || cnt_q == LAST) ?
                         (bus.req[0] ? GRANT_A : bus.req[1] ? GRANT_B : IDLE) : GRANT_B;
      default: state_d = IDLE;
    endcase
    cnt_d  = (state_d == state_q && state_q != IDLE && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    last_d = (state_d != state_q && state_d != IDLE) ? state_d == GRANT_B : last_q;
  end
  always_comb begin
    bus.gnt  = state_q == GRANT_A ? 2'b01 : state_q == GRANT_B ? 2'b10 : 2'b00;
    bus.busy = state_q != IDLE;
    bus.sel  = sel_q;
    sel_d    = state_d == GRANT_A ? 1'b0 : state_d == GRANT_B ? 1'b1 : sel_q;
  end
  assign bus.m = bus.gnt[0] ? bus.data_a : bus.gnt[1] ? bus.data_b : {WIDTH{1'b0}};
endmodule

// File: tb/tb_led_mux_arbiter.sv
// tb_led_mux_arbiter: directed checks of grant, handover, timeout and reset abort with MAX_HOLD=4
module tb_led_mux_arbiter;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  led_mux_arbiter_if #(.WIDTH(8)) bus ();
  led_mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wa;
    int wb;
    logic [7:0] exp_m;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.data_a = 8'h00;
    bus.data_b = 8'h00;
    step();
    step();
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_m", bus.m, 8'h00);
    bus.req = 2'b11;
    bus.data_a = 8'hA5;
    bus.data_b = 8'h5A;
    step();
    chk("req_in_rst", bus.gnt, 2'b00);
    rst = 1'b0;
    step();
    chk("first_gnt", bus.gnt, 2'b01);
    chk("first_sel", bus.sel, 1'b0);
    chk("first_m", bus.m, 8'hA5);
    chk("first_busy", bus.busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_a", bus.gnt, 2'b01);
    end
    step();
    chk("timeout_gnt", bus.gnt, 2'b10);
    chk("timeout_sel", bus.sel, 1'b1);
    chk("timeout_m", bus.m, 8'h5A);
    bus.req = 2'b01;
    step();
    chk("handover_a", bus.gnt, 2'b01);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("wrap_a", bus.gnt, 2'b01);
    end
    bus.data_a = 8'h3C;
    #1;
    chk("comb_m", bus.m, 8'h3C);
    bus.req = 2'b10;
    step();
    chk("rel_to_b", bus.gnt, 2'b10);
    chk("rel_to_b_sel", bus.sel, 1'b1);
    bus.req = 2'b00;
    step();
    chk("idle_gnt", bus.gnt, 2'b00);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_m", bus.m, 8'h00);
    chk("idle_sel_b", bus.sel, 1'b1);
    bus.req = 2'b01;
    step();
    chk("idle_to_a", bus.gnt, 2'b01);
    bus.req = 2'b00;
    step();
    chk("idle_sel_a", bus.sel, 1'b0);
    bus.req = 2'b11;
    step();
    chk("contend_b", bus.gnt, 2'b10);
    step();
    chk("b_cnt1", bus.gnt, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", bus.gnt, 2'b00);
    chk("async_m", bus.m, 8'h00);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_sel", bus.sel, 1'b0);
    step();
    chk("held_rst", bus.gnt, 2'b00);
    rst = 1'b0;
    step();
    chk("restart_a", bus.gnt, 2'b01);
    wa = 0;
    wb = 0;
    for (int i = 0; i < 300; i++) begin
      bus.req = 2'($urandom);
      bus.data_a = 8'($urandom);
      bus.data_b = 8'($urandom);
      step();
      exp_m = bus.gnt == 2'b01 ? bus.data_a : bus.gnt == 2'b10 ? bus.data_b : 8'h00;
      chk("rnd_onehot", bus.gnt == 2'b11, 1'b0);
      chk("rnd_m", bus.m, exp_m);
      chk("rnd_busy", bus.busy, bus.gnt != 2'b00);
      wa = (bus.req[0] && !bus.gnt[0]) ? wa + 1 : 0;
      wb = (bus.req[1] && !bus.gnt[1]) ? wb + 1 : 0;
      chk("rnd_wait", (wa <= 5) && (wb <= 5), 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
